timekeeper_bcd: RTL

- Parametrised time-of-day core that replaces the derived-clock hour/minute/second counter.
- Runs entirely on the board clock. A prescaler generates a one-cycle tick-enable.
- Keeps binary H:M:S and presents registered packed-BCD digits for the seven-segment interface.
- Adds run/freeze control, a valid/ready time-set port with range checking, 12/24-hour display mode, a day-rollover pulse and a sticky alarm.

---
 rtl/timekeeper_bcd.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/timekeeper_bcd.sv
`timescale 1ns/1ps
// Time-of-day core on the board clock: prescaled tick, binary H:M:S, registered
// packed-BCD digits, valid/ready time load, 12/24-hour display and sticky alarm.
module timekeeper_bcd #(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode12,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [4:0] set_h,
    input  logic [5:0] set_m,
    input  logic [5:0] set_s,
    output logic       set_err,
    input  logic       alarm_en,
    input  logic [4:0] alarm_h,
    input  logic [5:0] alarm_m,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       alarm
);

    localparam int unsigned DIV  = (TICK_HZ == 0) ? 0 : CLK_HZ / TICK_HZ;
    localparam int unsigned REM  = (TICK_HZ == 0) ? 1 : CLK_HZ % TICK_HZ;
    localparam int unsigned CW   = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (TICK_HZ == 0 || REM != 0 || DIV < 2) begin : g_bad_div
        $error("timekeeper_bcd: CLK_HZ/TICK_HZ must be an integer >= 2");
    end

    typedef enum logic [1:0] {
        ST_INIT,
        ST_READY,
        ST_HOLD
    } hs_state_e;

    hs_state_e state_q, state_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    hrs_q, hrs_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          tick_q, tick_d;
    logic          day_q, day_d;
    logic          err_q, err_d;

    logic [7:0]    hr_q, mn_q, sc_q;
    logic          pm_q, sec_pulse_q, day_pulse_q, alarm_q;

    logic          accept;
    logic          tick;
    logic          set_ok;
    logic          alarm_hit;
    logic [5:0]    hr_disp;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    // Load handshake: not ready out of reset, one dead cycle after each acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        set_ready = 1'b0;
        case (state_q)
            ST_INIT:  state_d = ST_READY;
            ST_READY: begin
                set_ready = 1'b1;
                if (set_valid) state_d = ST_HOLD;
            end
            ST_HOLD:  state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    assign accept = set_valid && (state_q == ST_READY);
    assign tick   = run && (cnt_q == LAST);
    assign set_ok = (set_h <= 5'd23) && (set_m <= 6'd59) && (set_s <= 6'd59);

    always_comb begin
        cnt_d  = cnt_q;
        hrs_d  = hrs_q;
        min_d  = min_q;
        sec_d  = sec_q;
        tick_d = 1'b0;
        day_d  = 1'b0;
        err_d  = 1'b0;
        if (run) cnt_d = tick ? '0 : cnt_q + 1'b1;
        // An accepted load swallows a coincident tick, legal or not.
        if (accept) begin
            if (set_ok) begin
                hrs_d = set_h;
                min_d = set_m;
                sec_d = set_s;
                cnt_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (tick) begin
            tick_d = 1'b1;
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d = '0;
                    if (hrs_q == 5'd23) begin
                        hrs_d = '0;
                        day_d = 1'b1;
                    end else begin
                        hrs_d = hrs_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            hrs_q  <= '0;
            min_q  <= '0;
            sec_q  <= '0;
            tick_q <= 1'b0;
            day_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hrs_q  <= hrs_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
            tick_q <= tick_d;
            day_q  <= day_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        hr_disp = {1'b0, hrs_q};
        if (mode12) begin
            if (hrs_q == 5'd0)      hr_disp = 6'd12;
            else if (hrs_q > 5'd12) hr_disp = {1'b0, hrs_q - 5'd12};
        end
    end

    assign alarm_hit = (alarm_h <= 5'd23) && (alarm_m <= 6'd59) &&
                       (hrs_q == alarm_h) && (min_q == alarm_m) && (sec_q == 6'd0);

    // Output stage trails H:M:S by one cycle; the pulses are delayed to match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_q        <= '0;
            mn_q        <= '0;
            sc_q        <= '0;
            pm_q        <= 1'b0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            hr_q        <= to_bcd(hr_disp);
            mn_q        <= to_bcd(min_q);
            sc_q        <= to_bcd(sec_q);
            pm_q        <= mode12 && (hrs_q >= 5'd12);
            sec_pulse_q <= tick_q;
            day_pulse_q <= day_q;
            if (!alarm_en)                  alarm_q <= 1'b0;
            else if (tick_q && alarm_hit)   alarm_q <= 1'b1;
        end
    end

    assign hr_bcd    = hr_q;
    assign min_bcd   = mn_q;
    assign sec_bcd   = sc_q;
    assign pm        = pm_q;
    assign sec_pulse = sec_pulse_q;
    assign day_pulse = day_pulse_q;
    assign alarm     = alarm_q;
    assign set_err   = err_q;

endmodule
